// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: lock-detector state encoding and the common error width.
package adpll_pkg;

    localparam int ADPLL_ERR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_SEARCH    = 3'd0,
        ST_LOCKING   = 3'd1,
        ST_LOCKED    = 3'd2,
        ST_UNLOCKING = 3'd3,
        ST_NO_REF    = 3'd4
    } lock_state_e;

    function automatic logic is_locked_state(lock_state_e s);
        return (s == ST_LOCKED) || (s == ST_UNLOCKING);
    endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// Two-flop synchroniser for the asynchronous reference clock followed by a
// registered rising-edge detect; strobe_o is high for one clk_i cycle per edge.
module ref_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic strobe_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic strobe_q, strobe_d;

    always_comb begin
        meta_d   = async_i;
        sync_d   = meta_q;
        prev_d   = sync_q;
        strobe_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            prev_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/adpll_lock_detector.sv
// Lock qualifier for the ADPLL: judges the phase error once per reference period,
// applies lock/unlock hysteresis, tracks peak error and flags a missing reference.
module adpll_lock_detector
    import adpll_pkg::*;
#(
    parameter int ERR_WIDTH      = ADPLL_ERR_WIDTH,
    parameter int LOCK_THRESH    = 4,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_COUNT   = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        fpga_clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        ref_clk_i,
    input  logic signed [ERR_WIDTH-1:0] error_i,
    output logic                        lock_o,
    output logic                        lock_lost_o,
    output logic                        ref_missing_o,
    output logic [2:0]                  state_o,
    output logic [ERR_WIDTH-2:0]        peak_err_o
);

    localparam logic [ERR_WIDTH-1:0] ERR_MIN  = {1'b1, {(ERR_WIDTH-1){1'b0}}};
    localparam logic [ERR_WIDTH-2:0] MAG_MAX  = '1;
    localparam logic [ERR_WIDTH-2:0] THRESH   = (ERR_WIDTH-1)'(LOCK_THRESH);
    localparam logic [CNT_WIDTH-1:0] LOCK_N   = CNT_WIDTH'(LOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_N = CNT_WIDTH'(UNLOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] TMO_N    = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic sample;

    ref_edge_sync u_ref_edge_sync (
        .clk_i    (fpga_clk_i),
        .rst_i    (reset_i),
        .async_i  (ref_clk_i),
        .strobe_o (sample)
    );

    lock_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] good_q, good_d;
    logic [CNT_WIDTH-1:0] bad_q, bad_d;
    logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
    logic [ERR_WIDTH-2:0] peak_q, peak_d;
    logic                 lock_q, lock_d;
    logic                 lost_q, lost_d;
    logic                 missing_q, missing_d;

    logic [ERR_WIDTH-1:0] err_neg;
    logic [ERR_WIDTH-2:0] err_mag;
    logic                 in_win;
    logic [CNT_WIDTH-1:0] good_inc;
    logic [CNT_WIDTH-1:0] bad_inc;

    // |error| with the most-negative code saturated to the largest magnitude
    always_comb begin
        err_neg = ~error_i + 1'b1;
        if (error_i == ERR_MIN) begin
            err_mag = MAG_MAX;
        end else if (error_i[ERR_WIDTH-1]) begin
            err_mag = err_neg[ERR_WIDTH-2:0];
        end else begin
            err_mag = error_i[ERR_WIDTH-2:0];
        end
        in_win   = (err_mag <= THRESH);
        good_inc = good_q + 1'b1;
        bad_inc  = bad_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        peak_d  = peak_q;
        lost_d  = 1'b0;
        tmo_d   = sample ? '0 : ((tmo_q == CNT_MAX) ? tmo_q : tmo_q + 1'b1);

        if (!enable_i) begin
            state_d = ST_SEARCH;
            good_d  = '0;
            bad_d   = '0;
            tmo_d   = '0;
        end else if (sample) begin
            // a sample beats a coincident timeout expiry
            case (state_q)
                ST_SEARCH: begin
                    if (in_win) begin
                        if (LOCK_COUNT == 1) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            peak_d  = '0;
                        end else begin
                            state_d = ST_LOCKING;
                            good_d  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_LOCKING: begin
                    if (!in_win) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                    end else if (good_inc == LOCK_N) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                        peak_d  = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
                ST_LOCKED: begin
                    if (err_mag > peak_q) peak_d = err_mag;
                    if (!in_win) begin
                        if (UNLOCK_COUNT == 1) begin
                            state_d = ST_SEARCH;
                            lost_d  = 1'b1;
                        end else begin
                            state_d = ST_UNLOCKING;
                            bad_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_UNLOCKING: begin
                    if (err_mag > peak_q) peak_d = err_mag;
                    if (in_win) begin
                        state_d = ST_LOCKED;
                        bad_d   = '0;
                    end else if (bad_inc == UNLOCK_N) begin
                        state_d = ST_SEARCH;
                        bad_d   = '0;
                        lost_d  = 1'b1;
                    end else begin
                        bad_d = bad_inc;
                    end
                end
                ST_NO_REF: begin
                    state_d = ST_SEARCH;
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end else if ((state_q != ST_NO_REF) && (tmo_q >= TMO_N)) begin
            state_d = ST_NO_REF;
            good_d  = '0;
            bad_d   = '0;
            lost_d  = is_locked_state(state_q);
        end

        lock_d    = is_locked_state(state_d);
        missing_d = (state_d == ST_NO_REF);
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_SEARCH;
            good_q    <= '0;
            bad_q     <= '0;
            tmo_q     <= '0;
            peak_q    <= '0;
            lock_q    <= 1'b0;
            lost_q    <= 1'b0;
            missing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            tmo_q     <= tmo_d;
            peak_q    <= peak_d;
            lock_q    <= lock_d;
            lost_q    <= lost_d;
            missing_q <= missing_d;
        end
    end

    assign lock_o        = lock_q;
    assign lock_lost_o   = lost_q;
    assign ref_missing_o = missing_q;
    assign state_o       = state_q;
    assign peak_err_o    = peak_q;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Bench for adpll_lock_detector: hand sequences, a vector table and randomized
// periods checked against a per-sample behavioural model.
module tb_adpll_lock_detector;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              ref1;
    logic              ref2;
    logic signed [7:0] err;

    logic       lock1, lost1, miss1;
    logic [2:0] st1;
    logic [6:0] peak1;
    logic       lock2, lost2, miss2;
    logic [2:0] st2;
    logic [6:0] peak2;

    always #5 clk = ~clk;

    adpll_lock_detector u_dut (
        .fpga_clk_i    (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .ref_clk_i     (ref1),
        .error_i       (err),
        .lock_o        (lock1),
        .lock_lost_o   (lost1),
        .ref_missing_o (miss1),
        .state_o       (st1),
        .peak_err_o    (peak1)
    );

    adpll_lock_detector #(.TIMEOUT_CYCLES(40)) u_dut_tmo (
        .fpga_clk_i    (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .ref_clk_i     (ref2),
        .error_i       (err),
        .lock_o        (lock2),
        .lock_lost_o   (lost2),
        .ref_missing_o (miss2),
        .state_o       (st2),
        .peak_err_o    (peak2)
    );

    int checks   = 0;
    int failures = 0;

    // pulse/level monitors sampled away from the active edge
    int lost1_cnt = 0;
    int lost2_cnt = 0;
    int miss2_cnt = 0;
    always @(negedge clk) begin
        if (lost1) lost1_cnt++;
        if (lost2) lost2_cnt++;
        if (miss2) miss2_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // behavioural model: run lengths of good/bad samples since the last decision
    int m_good, m_bad, m_peak, m_lost, m_lost_base;
    bit m_locked, m_noref;

    function automatic int sat_abs(input int e);
        int a;
        a = (e < 0) ? -e : e;
        if (a > 127) a = 127;
        return a;
    endfunction

    function automatic int m_state();
        if (m_noref) return 4;
        if (m_locked) return (m_bad > 0) ? 3 : 2;
        return (m_good > 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_good = 0; m_bad = 0; m_peak = 0; m_lost = 0;
        m_locked = 0; m_noref = 0; m_lost_base = lost1_cnt;
    endtask

    task automatic model_sample(input int e);
        int a;
        bit inw;
        a   = sat_abs(e);
        inw = (a <= 4);
        if (m_noref) begin
            m_noref = 0; m_good = 0; m_bad = 0;
        end else if (!m_locked) begin
            if (inw) begin
                m_good++;
                if (m_good >= 16) begin
                    m_locked = 1; m_good = 0; m_bad = 0; m_peak = 0;
                end
            end else begin
                m_good = 0;
            end
        end else begin
            if (a > m_peak) m_peak = a;
            if (inw) begin
                m_bad = 0;
            end else begin
                m_bad++;
                if (m_bad >= 4) begin
                    m_locked = 0; m_bad = 0; m_lost++;
                end
            end
        end
    endtask

    task automatic model_timeout();
        if (!m_noref) begin
            if (m_locked) m_lost++;
            m_noref = 1; m_locked = 0; m_good = 0; m_bad = 0;
        end
    endtask

    task automatic model_enable_low();
        m_locked = 0; m_noref = 0; m_good = 0; m_bad = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"}, int'(st1), m_state());
        chk({tag, "_lock"}, int'(lock1), int'(m_locked));
        chk({tag, "_peak"}, int'(peak1), m_peak);
        chk({tag, "_lost"}, lost1_cnt - m_lost_base, m_lost);
        chk({tag, "_missing"}, int'(miss1), int'(m_noref));
    endtask

    // one reference period of len cycles with constant error; starts and ends at a negedge
    int lock_rise_at;
    task automatic run_period(input bit sel, input int len, input int e);
        bit lock_start;
        err          = 8'(e);
        lock_start   = lock1;
        lock_rise_at = -1;
        if (sel) ref2 = 1'b1; else ref1 = 1'b1;
        for (int c = 1; c <= len; c++) begin
            @(posedge clk);
            #1;
            if (c == len / 2) begin
                if (sel) ref2 = 1'b0; else ref1 = 1'b0;
            end
            @(negedge clk);
            if (!lock_start && lock1 && lock_rise_at < 0) lock_rise_at = c;
        end
        if (!sel) model_sample(e);
    endtask

    typedef struct {
        int err;
        int st;
        int lk;
        int pk;
        int lost;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int base;
        int e;

        // rows start from LOCKED with peak 2; lost is cumulative over the table
        tbl[0]  = '{ 9,   3, 1,   9, 0};
        tbl[1]  = '{ 9,   3, 1,   9, 0};
        tbl[2]  = '{ 9,   3, 1,   9, 0};
        tbl[3]  = '{ 1,   2, 1,   9, 0};
        tbl[4]  = '{ 4,   2, 1,   9, 0};
        tbl[5]  = '{-4,   2, 1,   9, 0};
        tbl[6]  = '{-5,   3, 1,   9, 0};
        tbl[7]  = '{ 5,   3, 1,   9, 0};
        tbl[8]  = '{-128, 3, 1, 127, 0};
        tbl[9]  = '{-128, 0, 0, 127, 1};
        tbl[10] = '{ 4,   1, 0, 127, 1};
        tbl[11] = '{-4,   1, 0, 127, 1};
        tbl[12] = '{ 5,   0, 0, 127, 1};
        tbl[13] = '{-5,   0, 0, 127, 1};
        tbl[14] = '{-128, 0, 0, 127, 1};
        tbl[15] = '{ 0,   1, 0, 127, 1};

        rst = 1'b1; en = 1'b1; ref1 = 1'b0; ref2 = 1'b0; err = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        chk("reset_state", int'(st1), 0);
        chk("reset_lock", int'(lock1), 0);
        chk("reset_lost", int'(lost1), 0);
        chk("reset_missing", int'(miss1), 0);
        chk("reset_peak", int'(peak1), 0);

        // clean lock at +2
        run_period(0, 100, 2);
        chk("clean_first_locking", int'(st1), 1);
        for (int i = 0; i < 14; i++) run_period(0, 100, 2);
        chk("clean_15_nolock", int'(lock1), 0);
        run_period(0, 100, 2);
        chk("clean_lock_latency", lock_rise_at, 4);
        chk("clean_locked_state", int'(st1), 2);
        chk("clean_peak_cleared", int'(peak1), 0);
        run_period(0, 100, 2);
        chk("clean_peak", int'(peak1), 2);
        check_model("clean");

        // hysteresis and boundary table
        base = lost1_cnt;
        for (int i = 0; i < 16; i++) begin
            run_period(0, 50, tbl[i].err);
            chk($sformatf("tbl%0d_state", i), int'(st1), tbl[i].st);
            chk($sformatf("tbl%0d_lock", i), int'(lock1), tbl[i].lk);
            chk($sformatf("tbl%0d_peak", i), int'(peak1), tbl[i].pk);
            chk($sformatf("tbl%0d_lost", i), lost1_cnt - base, tbl[i].lost);
        end
        check_model("table");

        // relock then saturated error while locked
        for (int i = 0; i < 16; i++) run_period(0, 40, 1);
        check_model("relock");
        run_period(0, 40, -128);
        chk("sat_peak", int'(peak1), 127);
        chk("sat_unlocking", int'(st1), 3);
        run_period(0, 40, 0);
        check_model("sat_recover");

        // missing reference while locked
        base = lost1_cnt;
        repeat (4200) @(negedge clk);
        chk("noref_missing", int'(miss1), 1);
        chk("noref_lock", int'(lock1), 0);
        chk("noref_state", int'(st1), 4);
        chk("noref_lost_once", lost1_cnt - base, 1);
        model_timeout();
        check_model("noref");
        run_period(0, 40, 0);
        chk("restart_search", int'(st1), 0);
        chk("restart_missing", int'(miss1), 0);
        for (int i = 0; i < 15; i++) run_period(0, 40, 0);
        chk("restart_15_nolock", int'(lock1), 0);
        run_period(0, 40, 0);
        chk("restart_16_lock", int'(lock1), 1);
        check_model("restart");

        // randomized periods, errors and enable drops
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 255)) - 128;
            else e = int'($urandom_range(0, 12)) - 6;
            run_period(0, int'($urandom_range(12, 60)), e);
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0;
                repeat (2) @(negedge clk);
                en = 1'b1;
                model_enable_low();
                @(negedge clk);
            end
            check_model($sformatf("rnd%0d", i));
        end

        // enable low while locked
        for (int i = 0; i < 17; i++) run_period(0, 30, 0);
        chk("en_pre_lock", int'(lock1), 1);
        base = lost1_cnt;
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        model_enable_low();
        chk("en_state", int'(st1), 0);
        chk("en_lock", int'(lock1), 0);
        chk("en_no_lost", lost1_cnt - base, 0);
        chk("en_peak_kept", int'(peak1), m_peak);

        // timeout coinciding with a sample on the short-timeout instance
        for (int i = 0; i < 20; i++) run_period(1, 41, 0);
        chk("tmo_lock", int'(lock2), 1);
        base = lost2_cnt;
        e = miss2_cnt;
        for (int i = 0; i < 10; i++) run_period(1, 40, 0);
        for (int i = 0; i < 10; i++) run_period(1, 41, 0);
        chk("tmo_no_missing", miss2_cnt - e, 0);
        chk("tmo_still_locked", int'(st2), 2);
        chk("tmo_no_lost", lost2_cnt - base, 0);
        run_period(1, 60, 0);
        chk("tmo_expired_state", int'(st2), 4);
        chk("tmo_expired_lock", int'(lock2), 0);
        chk("tmo_expired_lost", lost2_cnt - base, 1);

        // asynchronous reset in the middle of LOCKING
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        for (int i = 0; i < 3; i++) run_period(0, 30, 0);
        chk("mid_locking", int'(st1), 1);
        base = lost1_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(st1), 0);
        chk("async_rst_lock", int'(lock1), 0);
        chk("async_rst_lost", int'(lost1), 0);
        chk("async_rst_missing", int'(miss1), 0);
        chk("async_rst_peak", int'(peak1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("async_rst_no_pulse", lost1_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
